// File: rtl/csr_spmv_engine_if.sv
// Bundled job-control, CSR/x RAM and result-stream signals for csr_spmv_engine.
// y_ovf exists only when SPMV_SATURATE_EN is defined.
interface csr_spmv_engine_if #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int LANES  = 2,
  parameter int NNZ_AW = 14,
  parameter int ROW_AW = 10,
  parameter int COL_AW = 10
) ();
  logic                      start;
  logic [ROW_AW-1:0]         num_rows;
  logic                      busy;
  logic                      done;
  logic [ROW_AW:0]           row_addr;
  logic [NNZ_AW:0]           row_ptr;
  logic [NNZ_AW-1:0]         nz_addr;
  logic [DATA_W-1:0]         nz_val;
  logic [COL_AW-1:0]         nz_col;
  logic [COL_AW-1:0]         x_addr;
  logic [LANES*DATA_W-1:0]   x_data;
  logic                      y_valid;
  logic                      y_ready;
  logic [ROW_AW-1:0]         y_row;
  logic [LANES*ACC_W-1:0]    y_data;
  logic                      y_zero;
`ifdef SPMV_SATURATE_EN
  logic                      y_ovf;
`endif

  modport master (
`ifdef SPMV_SATURATE_EN
    output y_ovf,
`endif
    input  start, num_rows, row_ptr, nz_val, nz_col, x_data, y_ready,
    output busy, done, row_addr, nz_addr, x_addr, y_valid, y_row, y_data, y_zero
  );

  modport slave (
`ifdef SPMV_SATURATE_EN
    input  y_ovf,
`endif
    output start, num_rows, row_ptr, nz_val, nz_col, x_data, y_ready,
    input  busy, done, row_addr, nz_addr, x_addr, y_valid, y_row, y_data, y_zero
  );
endinterface

// File: rtl/csr_spmv_engine.sv
// CSR sparse-matrix x dense multi-vector engine: y[r][l] = sum_k A[r][k]*x[k][l], one row per stream beat.
// Define SPMV_SATURATE_EN for saturating per-lane accumulation and the sticky y_ovf flag.
module csr_spmv_engine #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 64,
  parameter int LANES  = 2,
  parameter int NNZ_AW = 14,
  parameter int ROW_AW = 10,
  parameter int COL_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  csr_spmv_engine_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PTR0, S_PTR, S_FETCH, S_DRAIN, S_EMIT, S_FIN
  } state_t;

  state_t                    r_state;
  logic [ROW_AW-1:0]         r_rows;
  logic [ROW_AW-1:0]         r_row;
  logic [NNZ_AW:0]           r_ptr_lo;
  logic [NNZ_AW:0]           r_ptr_hi;
  logic [NNZ_AW:0]           r_left;
  logic                      r_ph;
  logic                      r_first;
  logic [ROW_AW:0]           r_row_addr;
  logic [NNZ_AW-1:0]         r_nz_addr;
  logic                      r_y_valid;
  logic [ROW_AW-1:0]         r_y_row;
  logic [LANES*ACC_W-1:0]    r_y_data;
  logic                      r_y_zero;
  logic                      r_busy;
  logic                      r_done;

  logic                      r_v1, r_f1, r_v2, r_f2, r_v3, r_f3;
  logic signed [DATA_W-1:0]  r_val2;
  logic signed [ACC_W-1:0]   r_prod [LANES];
  logic signed [ACC_W-1:0]   r_acc  [LANES];

  logic                      w_issue;
  logic signed [DATA_W-1:0]  w_xl   [LANES];
  logic signed [2*DATA_W-1:0] w_mul [LANES];
  logic signed [ACC_W-1:0]   w_sum  [LANES];
  logic [LANES*ACC_W-1:0]    w_acc_flat;
  logic [ROW_AW:0]           w_row_nxt;

`ifdef SPMV_SATURATE_EN
  logic [LANES-1:0]          w_lane_ovf;
  logic                      r_ovf;
  logic                      r_y_ovf;
  assign bus.y_ovf = r_y_ovf;
`endif

  assign w_issue   = (r_state == S_FETCH);
  assign w_row_nxt = (ROW_AW+1)'(r_row) + (ROW_AW+1)'(1);

  always_comb begin
    w_acc_flat = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_xl[l]  = bus.x_data[l*DATA_W +: DATA_W];
      w_mul[l] = (2*DATA_W)'(r_val2) * (2*DATA_W)'(w_xl[l]);
      w_acc_flat[l*ACC_W +: ACC_W] = r_acc[l];
    end
  end

  // Same-sign operands producing an opposite-sign sum is the overflow condition.
  always_comb begin
`ifdef SPMV_SATURATE_EN
    w_lane_ovf = '0;
`endif
    for (int unsigned l = 0; l < LANES; l++) begin
      w_sum[l] = r_acc[l] + r_prod[l];
`ifdef SPMV_SATURATE_EN
      if ((r_acc[l][ACC_W-1] == r_prod[l][ACC_W-1]) &&
          (w_sum[l][ACC_W-1] != r_acc[l][ACC_W-1])) begin
        w_lane_ovf[l] = 1'b1;
        w_sum[l] = r_acc[l][ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
      end
`endif
    end
  end

  // Product pipeline: c1 val/col, c2 x_data with val delayed, c3 product, c4 accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1   <= 1'b0;
      r_f1   <= 1'b0;
      r_v2   <= 1'b0;
      r_f2   <= 1'b0;
      r_v3   <= 1'b0;
      r_f3   <= 1'b0;
      r_val2 <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        r_prod[l] <= '0;
        r_acc[l]  <= '0;
      end
`ifdef SPMV_SATURATE_EN
      r_ovf  <= 1'b0;
`endif
    end else begin
      r_v1   <= w_issue;
      r_f1   <= w_issue & r_first;
      r_v2   <= r_v1;
      r_f2   <= r_f1;
      r_val2 <= bus.nz_val;
      r_v3   <= r_v2;
      r_f3   <= r_f2;
      for (int unsigned l = 0; l < LANES; l++) begin
        r_prod[l] <= ACC_W'(w_mul[l]);
      end
      if (r_v3) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          r_acc[l] <= r_f3 ? r_prod[l] : w_sum[l];
        end
`ifdef SPMV_SATURATE_EN
        r_ovf <= r_f3 ? 1'b0 : (r_ovf | (|w_lane_ovf));
`endif
      end
    end
  end

  // Each PTR visit spends phase 0 waiting on the RAM and decides in phase 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_rows     <= '0;
      r_row      <= '0;
      r_ptr_lo   <= '0;
      r_ptr_hi   <= '0;
      r_left     <= '0;
      r_ph       <= 1'b0;
      r_first    <= 1'b0;
      r_row_addr <= '0;
      r_nz_addr  <= '0;
      r_y_valid  <= 1'b0;
      r_y_row    <= '0;
      r_y_data   <= '0;
      r_y_zero   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef SPMV_SATURATE_EN
      r_y_ovf    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.num_rows == '0) begin
              r_done <= 1'b1;
            end else begin
              r_rows     <= bus.num_rows;
              r_row      <= '0;
              r_row_addr <= '0;
              r_busy     <= 1'b1;
              r_state    <= S_PTR0;
            end
          end
        end
        S_PTR0: begin
          r_row_addr <= (ROW_AW+1)'(1);
          r_ph       <= 1'b0;
          r_state    <= S_PTR;
        end
        S_PTR: begin
          if (!r_ph) begin
            r_ph <= 1'b1;
            if (r_row == '0) r_ptr_lo <= bus.row_ptr;
          end else begin
            r_ph     <= 1'b0;
            r_ptr_hi <= bus.row_ptr;
            if (bus.row_ptr > r_ptr_lo) begin
              r_nz_addr <= r_ptr_lo[NNZ_AW-1:0];
              r_left    <= bus.row_ptr - r_ptr_lo;
              r_first   <= 1'b1;
              r_state   <= S_FETCH;
            end else begin
              r_y_valid <= 1'b1;
              r_y_zero  <= 1'b1;
              r_y_row   <= r_row;
              r_y_data  <= '0;
`ifdef SPMV_SATURATE_EN
              r_y_ovf   <= 1'b0;
`endif
              r_state   <= S_EMIT;
            end
          end
        end
        S_FETCH: begin
          r_first <= 1'b0;
          if (r_left == (NNZ_AW+1)'(1)) begin
            r_state <= S_DRAIN;
          end else begin
            r_nz_addr <= r_nz_addr + NNZ_AW'(1);
            r_left    <= r_left - (NNZ_AW+1)'(1);
          end
        end
        S_DRAIN: begin
          if (!r_v1 && !r_v2 && !r_v3) begin
            r_y_valid <= 1'b1;
            r_y_zero  <= 1'b0;
            r_y_row   <= r_row;
            r_y_data  <= w_acc_flat;
`ifdef SPMV_SATURATE_EN
            r_y_ovf   <= r_ovf;
`endif
            r_state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.y_ready) begin
            r_y_valid <= 1'b0;
            r_ptr_lo  <= r_ptr_hi;
            if (w_row_nxt == (ROW_AW+1)'(r_rows)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_row      <= r_row + ROW_AW'(1);
              r_row_addr <= w_row_nxt + (ROW_AW+1)'(1);
              r_ph       <= 1'b0;
              r_state    <= S_PTR;
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.row_addr = r_row_addr;
  assign bus.nz_addr  = r_nz_addr;
  assign bus.x_addr   = bus.nz_col;
  assign bus.y_valid  = r_y_valid;
  assign bus.y_row    = r_y_row;
  assign bus.y_data   = r_y_data;
  assign bus.y_zero   = r_y_zero;

endmodule

// File: tb/tb_csr_spmv_engine.sv
// Bench for csr_spmv_engine: RAM models, arithmetic reference of every result row, and stream/hold checks.
module tb_csr_spmv_engine;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int LANES  = 2;
  localparam int NNZ_AW = 6;
  localparam int ROW_AW = 4;
  localparam int COL_AW = 4;
  localparam int NNZ_N  = 2**NNZ_AW;
  localparam longint ACC_MAX = (longint'(1) <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (ACC_W-1));

  typedef struct {
    int                     row;
    logic [LANES*ACC_W-1:0] data;
    logic                   zero;
    logic                   ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_spmv_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES),
                       .NNZ_AW(NNZ_AW), .ROW_AW(ROW_AW), .COL_AW(COL_AW)) bus ();

  csr_spmv_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES),
                    .NNZ_AW(NNZ_AW), .ROW_AW(ROW_AW), .COL_AW(COL_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NNZ_AW:0]          rp_mem  [2**(ROW_AW+1)];
  logic signed [DATA_W-1:0] val_mem [NNZ_N];
  logic [COL_AW-1:0]        col_mem [NNZ_N];
  logic signed [DATA_W-1:0] x_mem   [2**COL_AW][LANES];

  always @(posedge clk) begin
    bus.row_ptr <= rp_mem[bus.row_addr];
    bus.nz_val  <= val_mem[bus.nz_addr];
    bus.nz_col  <= col_mem[bus.nz_addr];
    for (int l = 0; l < LANES; l++) bus.x_data[l*DATA_W +: DATA_W] <= x_mem[bus.x_addr][l];
  end

  int n_err = 0, n_chk = 0;
  int done_cnt = 0, rows_got = 0, valid_cnt = 0;
  exp_t exp_q[$];

  task automatic chk(input bit ok, input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic signed [ACC_W-1:0] lane(input logic [LANES*ACC_W-1:0] d, input int l);
    return d[l*ACC_W +: ACC_W];
  endfunction

`ifndef SPMV_SATURATE_EN
  function automatic longint wrap(input longint v);
    logic signed [ACC_W-1:0] t;
    t = v[ACC_W-1:0];
    return longint'(t);
  endfunction
`endif

  // Reference: row r covers nonzeros rp[r]..rp[r+1]-1; empty when rp[r+1] <= rp[r].
  task automatic build_expected(input int n);
    exp_q.delete();
    for (int r = 0; r < n; r++) begin
      exp_t e;
      int lo, hi;
      lo = int'(rp_mem[r]);
      hi = int'(rp_mem[r+1]);
      e.row = r; e.zero = (hi <= lo); e.ovf = 1'b0; e.data = '0;
      for (int l = 0; l < LANES; l++) begin
        longint acc = 0;
        for (int k = lo; k < hi; k++) begin
          int a = k % NNZ_N;
          acc += longint'(val_mem[a]) * longint'(x_mem[col_mem[a]][l]);
`ifdef SPMV_SATURATE_EN
          if (acc > ACC_MAX) begin acc = ACC_MAX; e.ovf = 1'b1; end
          else if (acc < ACC_MIN) begin acc = ACC_MIN; e.ovf = 1'b1; end
`else
          acc = wrap(acc);
`endif
        end
        e.data[l*ACC_W +: ACC_W] = acc[ACC_W-1:0];
      end
      exp_q.push_back(e);
    end
  endtask

  bit                     hold_pending = 1'b0;
  logic [ROW_AW-1:0]      h_row;
  logic [LANES*ACC_W-1:0] h_data;
  logic [NNZ_AW-1:0]      h_nz;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.done) done_cnt++;
      if (bus.y_valid) valid_cnt++;
      if (hold_pending)
        chk(bus.y_valid === 1'b1 && bus.y_row === h_row && bus.y_data === h_data && bus.nz_addr === h_nz,
            "emit_hold", bus.y_data, h_data);
      hold_pending = 1'b0;
      if (bus.y_valid && !bus.y_ready) begin
        hold_pending = 1'b1;
        h_row = bus.y_row; h_data = bus.y_data; h_nz = bus.nz_addr;
      end
      if (bus.y_valid && bus.y_ready) begin
        rows_got++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_row", 64'(bus.y_row), 64'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(bus.y_row == ROW_AW'(e.row), "y_row", 64'(bus.y_row), 64'(e.row));
          chk(bus.y_data === e.data, "y_data", bus.y_data, e.data);
          chk(bus.y_zero === e.zero, "y_zero", 64'(bus.y_zero), 64'(e.zero));
`ifdef SPMV_SATURATE_EN
          chk(bus.y_ovf === e.ovf, "y_ovf", 64'(bus.y_ovf), 64'(e.ovf));
`endif
        end
      end
    end else begin
      hold_pending = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 2**(ROW_AW+1); i++) rp_mem[i] = '0;
    for (int i = 0; i < NNZ_N; i++) begin val_mem[i] = '0; col_mem[i] = '0; end
    for (int c = 0; c < 2**COL_AW; c++)
      for (int l = 0; l < LANES; l++) x_mem[c][l] = '0;
  endtask

  task automatic set_nz(input int k, input int v, input int c);
    val_mem[k] = DATA_W'(v);
    col_mem[k] = COL_AW'(c);
  endtask

  task automatic outputs_zero(input string nm);
    chk({bus.row_addr, bus.nz_addr, bus.y_valid, bus.y_row, bus.y_zero, bus.busy, bus.done} == '0,
        {nm, "_ctrl"}, 64'({bus.row_addr, bus.nz_addr, bus.y_valid, bus.y_row, bus.y_zero, bus.busy, bus.done}), 64'(0));
    chk(bus.y_data == '0, {nm, "_ydata"}, bus.y_data, 64'(0));
`ifdef SPMV_SATURATE_EN
    chk(bus.y_ovf == 1'b0, {nm, "_ovf"}, 64'(bus.y_ovf), 64'(0));
`endif
  endtask

  // mode 0: ready always high; 1: ready low every third cycle; 2: first row stalled 10 cycles.
  task automatic run_job(input int n, input int mode, input bit poke, input string nm);
    int cyc = 0;
    int stall = 0;
    build_expected(n);
    done_cnt = 0; rows_got = 0;
    bus.num_rows = ROW_AW'(n);
    bus.start = 1'b1;
    bus.y_ready = (mode != 2);
    step();
    bus.start = 1'b0;
    while (done_cnt == 0 && cyc < 2000) begin
      case (mode)
        0: bus.y_ready = 1'b1;
        1: bus.y_ready = (cyc % 3) != 1;
        default: begin
          if (bus.y_valid && stall < 10) begin bus.y_ready = 1'b0; stall++; end
          else bus.y_ready = 1'b1;
        end
      endcase
      bus.start    = poke && cyc == 4;
      bus.num_rows = (poke && cyc == 4) ? ROW_AW'(n + 3) : ROW_AW'(n);
      step();
      cyc++;
    end
    bus.start = 1'b0;
    chk(done_cnt != 0, {nm, "_timeout"}, 64'(cyc), 64'(2000));
    repeat (3) step();
    chk(done_cnt == 1, {nm, "_done_once"}, 64'(done_cnt), 64'(1));
    chk(rows_got == n, {nm, "_rows"}, 64'(rows_got), 64'(n));
    chk(exp_q.size() == 0, {nm, "_left"}, 64'(exp_q.size()), 64'(0));
    chk(bus.busy == 1'b0, {nm, "_busy_end"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic load_t1();
    clear_mem();
    rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 2; rp_mem[3] = 5;
    set_nz(0, 3, 0); set_nz(1, -1, 3); set_nz(2, 4, 1); set_nz(3, 2, 2); set_nz(4, -7, 3);
    for (int c = 0; c < 4; c++) begin
      x_mem[c][0] = DATA_W'(c + 1);
      x_mem[c][1] = DATA_W'(-3 + 5*c);
    end
  endtask

  task automatic load_t2();
    clear_mem();
    rp_mem[0] = 0; rp_mem[1] = 1; rp_mem[2] = 2;
    set_nz(0, 2, 0); set_nz(1, 3, 1);
    x_mem[0][0] = 1;  x_mem[0][1] = -5;
    x_mem[1][0] = 4;  x_mem[1][1] = 7;
  endtask

  initial begin
    int cyc;
    bus.start = 1'b0; bus.num_rows = '0; bus.y_ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    outputs_zero("reset");
    @(posedge clk); #1 rst = 1'b1;
    step();

    // CSR with an empty middle row
    load_t1();
    build_expected(3);
    chk(lane(exp_q[0].data, 0) == -1,  "pin_t1_r0l0", 64'(lane(exp_q[0].data, 0)), 64'(-1));
    chk(lane(exp_q[0].data, 1) == -21, "pin_t1_r0l1", 64'(lane(exp_q[0].data, 1)), 64'(-21));
    chk(exp_q[1].zero == 1'b1,         "pin_t1_r1z",  64'(exp_q[1].zero), 64'(1));
    chk(lane(exp_q[2].data, 1) == -62, "pin_t1_r2l1", 64'(lane(exp_q[2].data, 1)), 64'(-62));
    run_job(3, 0, 1'b0, "t1");
    run_job(3, 1, 1'b0, "t1_bp");

    // Decreasing row pointer is an empty row
    rp_mem[1] = 3; rp_mem[2] = 1; rp_mem[3] = 4;
    build_expected(3);
    chk(lane(exp_q[0].data, 0) == 7,  "pin_dec_r0", 64'(lane(exp_q[0].data, 0)), 64'(7));
    chk(exp_q[1].zero == 1'b1,        "pin_dec_r1", 64'(exp_q[1].zero), 64'(1));
    chk(lane(exp_q[2].data, 0) == 10, "pin_dec_r2", 64'(lane(exp_q[2].data, 0)), 64'(10));
    run_job(3, 0, 1'b0, "dec");

    // Diagonal 2x2
    load_t2();
    build_expected(2);
    chk(lane(exp_q[0].data, 0) == 2,   "pin_t2_y00", 64'(lane(exp_q[0].data, 0)), 64'(2));
    chk(lane(exp_q[0].data, 1) == -10, "pin_t2_y01", 64'(lane(exp_q[0].data, 1)), 64'(-10));
    chk(lane(exp_q[1].data, 0) == 12,  "pin_t2_y10", 64'(lane(exp_q[1].data, 0)), 64'(12));
    chk(lane(exp_q[1].data, 1) == 21,  "pin_t2_y11", 64'(lane(exp_q[1].data, 1)), 64'(21));
    run_job(2, 0, 1'b0, "t2");
    run_job(2, 2, 1'b0, "t3_stall");

    // Zero-row job, then start pulses while busy
    done_cnt = 0; valid_cnt = 0;
    bus.num_rows = '0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    @(negedge clk);
    chk(bus.done === 1'b1, "t4_zero_done", 64'(bus.done), 64'(1));
    repeat (5) step();
    chk(done_cnt == 1, "t4_zero_done_once", 64'(done_cnt), 64'(1));
    chk(valid_cnt == 0, "t4_zero_no_valid", 64'(valid_cnt), 64'(0));
    run_job(2, 0, 1'b1, "t4_busy_start");

    // Reset while fetching row 1, then full rerun
    build_expected(2);
    done_cnt = 0; rows_got = 0;
    bus.y_ready = 1'b1; bus.num_rows = ROW_AW'(2); bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 0;
    while (!(rows_got >= 1 && bus.nz_addr == NNZ_AW'(1)) && cyc < 200) begin
      step();
      cyc++;
    end
    chk(cyc < 200, "t5_reach_fetch", 64'(cyc), 64'(200));
    rst = 1'b0;
    @(negedge clk);
    outputs_zero("t5_rst");
    repeat (3) step();
    chk(done_cnt == 0, "t5_no_done", 64'(done_cnt), 64'(0));
    rst = 1'b1;
    step();
    run_job(2, 0, 1'b0, "t5_restart");

    // Accumulator overflow on lane 0
    clear_mem();
    rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 3;
    set_nz(0, -32768, 0); set_nz(1, -32768, 0); set_nz(2, 1, 0);
    x_mem[0][0] = -32768; x_mem[0][1] = 1;
    build_expected(2);
`ifdef SPMV_SATURATE_EN
    chk(lane(exp_q[0].data, 0) == 32'h7FFFFFFF, "pin_t6_sat", 64'(lane(exp_q[0].data, 0)), 64'h7FFFFFFF);
    chk(exp_q[0].ovf == 1'b1, "pin_t6_ovf", 64'(exp_q[0].ovf), 64'(1));
`else
    chk(lane(exp_q[0].data, 0) == 32'h80000000, "pin_t6_wrap", 64'(lane(exp_q[0].data, 0)), 64'h80000000);
`endif
    chk(lane(exp_q[0].data, 1) == -65536, "pin_t6_l1", 64'(lane(exp_q[0].data, 1)), 64'(-65536));
    run_job(2, 0, 1'b0, "t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
